input_conditioner: RTL and testbench
====================================

# input_conditioner

Conditions the four raw board push-buttons before they reach the raccoon controller and the game-state machine. Each button is synchronised and debounced. The block produces single-cycle movement pulses, with optional auto-repeat while a button is held. It also decodes the held multi-button chords into one-shot start and reset pulses, which replace the raw combinational AND terms at top level.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000: cycles a synchronised input must differ from its stable value before the stable value flips (10 ms at 25 MHz).
- REPEAT_DELAY, 12500000: cycles from press edge to first auto-repeat pulse (500 ms).
- REPEAT_PERIOD, 3125000: cycles between subsequent auto-repeat pulses (125 ms).
- CHORD_HOLD, 25000000: cycles a chord must be held continuously before its pulse fires (1 s).

Ports:
- i_Clk  in  1  system clock (25 MHz); single clock domain.
- i_Reset  in  1  synchronous, active-high reset.
- i_Switch_1..i_Switch_4  in  1 each  raw asynchronous buttons, active-high (1 = up, 2 = down, 3 = right, 4 = left).
- o_Buttons  out  4  debounced stable levels; bit 0 = Switch_1.
- o_Up_Pulse, o_Dn_Pulse, o_Rt_Pulse, o_Lt_Pulse  out  1 each  one-cycle move strobes.
- o_Start_Pulse  out  1  one-cycle strobe for the start chord.
- o_Reset_Pulse  out  1  one-cycle strobe for the reset chord.

## Operation
- **Synchroniser:** two-flop synchroniser per input. The debouncer sees only synchronised values.
- **Debounce, per button:**
  - While synced equals stable, the counter is held at 0.
  - While they differ, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, stable takes the synced value and the counter clears.
  - Any return to agreement before then clears the counter.
  - Counter widths cover their parameter; no wrap-around.
- **Press edge:** stable goes 0 to 1.
- **Move pulses:**
  - Generated only while exactly one bit of o_Buttons is high (single-button mode).
  - A press edge in single-button mode gives one pulse on the matching output.
  - A shared repeat counter is reset on every press edge and whenever the one-hot condition is lost.
  - The four move outputs are mutually exclusive.
- **Chord FSM, states IDLE, ARM, FIRED:**
  - Reset chord is o_Buttons == 4'b1111. Start chord is 4'b0111. Reset chord has priority.
  - IDLE goes to ARM when either chord is present; the hold counter clears and the current chord is latched.
  - ARM counts while the latched chord remains exact.
  - If the chord changes to the other chord, ARM stays and the counter clears with the new chord latched.
  - If the chord changes to a non-chord, the FSM returns to IDLE.
  - When the counter reaches CHORD_HOLD-1, the matching pulse is asserted for one cycle and the FSM goes to FIRED.
  - FIRED goes to IDLE only when o_Buttons == 0. No further chord pulses fire until then.
- **Move/chord interaction:** move pulses never fire while any chord state is ARM or FIRED with two or more buttons high. This follows from the single-button rule.
- **Reset mid-operation:** i_Reset clears everything on the next edge. This includes the synchroniser flops, stable levels, all counters and the FSM, and aborts any in-progress debounce, repeat or chord count.

## Timing
- All outputs are registered. Every output is 0 after reset; the FSM is in IDLE.
- **Raw edge to o_Buttons change:** 2 (sync) + DEBOUNCE_CYCLES cycles for a clean step.
- **Move pulse:** asserted the cycle after o_Buttons rises; high exactly 1 cycle.
- **Auto-repeat pulses** (macro enabled): at press-pulse cycle + REPEAT_DELAY, then every REPEAT_PERIOD while the button stays single and held.
- **Chord pulse:** asserted CHORD_HOLD cycles after the cycle the exact chord first appears on o_Buttons; high exactly 1 cycle.

## Configuration
- INPUT_AUTOREPEAT_EN defined: the repeat counter and auto-repeat pulses are compiled in.
- INPUT_AUTOREPEAT_EN undefined: the repeat counter is absent and exactly one move pulse is issued per press edge regardless of hold duration. All other behaviour is identical.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, CHORD_HOLD=8.
- **Clean press:** Switch_1 raised at cycle 0 → o_Buttons[0]=1 at cycle 6; o_Up_Pulse high only at cycle 7.
- **Glitch rejection:** Switch_2 high for 3 cycles then low → o_Buttons stays 0; no o_Dn_Pulse.
- **Auto-repeat:** Switch_3 held for 30 cycles after its first pulse at cycle T → o_Rt_Pulse at T, T+10, T+15, T+20, T+25. With INPUT_AUTOREPEAT_EN undefined, only at T.
- **Start chord:** Switch_1/2/3 held together → exactly one o_Start_Pulse 8 cycles after o_Buttons==4'b0111; no move pulses while three are held. Holding on for 50 cycles gives no second pulse until all are released.
- **Reset chord escalation:** start chord held 5 cycles, then Switch_4 added → the counter restarts; o_Reset_Pulse fires 8 cycles after 4'b1111 and o_Start_Pulse never fires.
- **Reset mid-chord:** i_Reset asserted at hold count 6 of a reset chord → all outputs 0 on the next cycle. The chord still held after reset needs full debounce plus 8 more cycles before o_Reset_Pulse.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: synchronise and debounce the four board buttons, then decode them into move and chord strobes
// Optional feature: define INPUT_AUTOREPEAT_EN to compile in the auto-repeat counter and repeat move pulses.
// Ports:
//   i_Clk, i_Reset            25 MHz clock, synchronous active-high reset
//   i_Switch_1..i_Switch_4    raw asynchronous buttons, active-high (up, down, right, left)
//   o_Buttons[3:0]            debounced stable levels, bit 0 = Switch_1
//   o_Up/Dn/Rt/Lt_Pulse       one-cycle move strobes, only while exactly one button is held
//   o_Start_Pulse             one-cycle strobe once 4'b0111 has been held CHORD_HOLD cycles
//   o_Reset_Pulse             one-cycle strobe once 4'b1111 has been held CHORD_HOLD cycles
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 3125000,
  parameter int CHORD_HOLD      = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic [3:0] o_Buttons,
  output logic       o_Up_Pulse,
  output logic       o_Dn_Pulse,
  output logic       o_Rt_Pulse,
  output logic       o_Lt_Pulse,
  output logic       o_Start_Pulse,
  output logic       o_Reset_Pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(CHORD_HOLD + 1);
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_FIRED} state_t;
  logic [3:0] w_Raw, r_Sync1, r_Sync2, w_Stable, r_Stable_D, w_Press, w_Move, r_Move;
  logic w_One_Hot, w_Is_Rst, w_Is_Start, w_Chord;
  state_t r_State, w_State_Next;
  logic [HW-1:0] r_Hold_Cnt, w_Hold_Next, w_Hold_Inc;
  logic r_Latch_Rst, w_Latch_Next, r_Start_Pulse, w_Start_Next, r_Reset_Pulse, w_Reset_Next;
  assign w_Raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
  always_ff @(posedge i_Clk) begin
    r_Sync1    <= i_Reset ? 4'd0 : w_Raw;
    r_Sync2    <= i_Reset ? 4'd0 : r_Sync1;
    r_Stable_D <= i_Reset ? 4'd0 : w_Stable;
    r_Move     <= i_Reset ? 4'd0 : w_Move;
  end
  for (genvar d = 0; d < 4; d++) begin : g_db
    logic [DW-1:0] r_Cnt;
    logic          r_Level;
    always_ff @(posedge i_Clk)
      if (i_Reset) begin
        r_Cnt   <= '0;
        r_Level <= 1'b0;
      end else if (r_Sync2[d] == r_Level) r_Cnt <= '0;
      else if (r_Cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        r_Cnt   <= '0;
        r_Level <= r_Sync2[d];
      end else r_Cnt <= r_Cnt + DW'(1);
    assign w_Stable[d] = r_Level;
  end
  assign w_Press   = w_Stable & ~r_Stable_D;
  assign w_One_Hot = (w_Stable != 4'd0) && ((w_Stable & (w_Stable - 4'd1)) == 4'd0);
`ifdef INPUT_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] r_Rep_Cnt, w_Rep_Limit;
  logic r_Rep_Phase, w_Rep_Clr, w_Rep_Fire;
  // Phase 0 waits out the initial delay after the press pulse, phase 1 repeats at the period
  assign w_Rep_Clr   = !w_One_Hot || (w_Press != 4'd0);
  assign w_Rep_Limit = r_Rep_Phase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
  assign w_Rep_Fire  = !w_Rep_Clr && (r_Rep_Cnt == w_Rep_Limit);
  always_ff @(posedge i_Clk)
    if (i_Reset || w_Rep_Clr) begin
      r_Rep_Cnt   <= '0;
      r_Rep_Phase <= 1'b0;
    end else if (w_Rep_Fire) begin
      r_Rep_Cnt   <= '0;
      r_Rep_Phase <= 1'b1;
    end else r_Rep_Cnt <= r_Rep_Cnt + RW'(1);
  assign w_Move = w_One_Hot ? (w_Press | (w_Rep_Fire ? w_Stable : 4'd0)) : 4'd0;
`else
  assign w_Move = w_One_Hot ? w_Press : 4'd0;
`endif
  assign w_Is_Rst   = w_Stable == 4'b1111;
  assign w_Is_Start = w_Stable == 4'b0111;
  assign w_Chord    = w_Is_Rst || w_Is_Start;
  assign w_Hold_Inc = r_Hold_Cnt + HW'(1);
  always_ff @(posedge i_Clk)
    if (i_Reset) begin
      r_State       <= S_IDLE;
      r_Hold_Cnt    <= '0;
      r_Latch_Rst   <= 1'b0;
      r_Start_Pulse <= 1'b0;
      r_Reset_Pulse <= 1'b0;
    end else begin
      r_State       <= w_State_Next;
      r_Hold_Cnt    <= w_Hold_Next;
      r_Latch_Rst   <= w_Latch_Next;
      r_Start_Pulse <= w_Start_Next;
      r_Reset_Pulse <= w_Reset_Next;
    end
  // The strobe is registered, so it is launched on the edge where the count steps to CHORD_HOLD-1;
  // that lands it exactly CHORD_HOLD cycles after the chord first shows on o_Buttons
  always_comb begin
    w_State_Next = r_State;
    w_Hold_Next  = r_Hold_Cnt;
    w_Latch_Next = r_Latch_Rst;
    w_Start_Next = 1'b0;
    w_Reset_Next = 1'b0;
    case (r_State)
      S_IDLE:
        if (w_Chord) begin
          w_State_Next = S_ARM;
          w_Hold_Next  = '0;
          w_Latch_Next = w_Is_Rst;
        end
      S_ARM:
        if (!w_Chord) w_State_Next = S_IDLE;
        else if (w_Is_Rst != r_Latch_Rst) begin
          w_Hold_Next  = '0;
          w_Latch_Next = w_Is_Rst;
        end else if (w_Hold_Inc == HW'(CHORD_HOLD - 1)) begin
          w_State_Next = S_FIRED;
          w_Hold_Next  = w_Hold_Inc;
          w_Start_Next = !r_Latch_Rst;
          w_Reset_Next = r_Latch_Rst;
        end else w_Hold_Next = w_Hold_Inc;
      S_FIRED: w_State_Next = (w_Stable == 4'd0) ? S_IDLE : S_FIRED;
      default: w_State_Next = S_IDLE;
    endcase
  end
  assign o_Buttons     = w_Stable;
  assign o_Up_Pulse    = r_Move[0];
  assign o_Dn_Pulse    = r_Move[1];
  assign o_Rt_Pulse    = r_Move[2];
  assign o_Lt_Pulse    = r_Move[3];
  assign o_Start_Pulse = r_Start_Pulse;
  assign o_Reset_Pulse = r_Reset_Pulse;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed per-cycle checks of debounce, move pulses, auto-repeat and chord strobes
module tb_input_conditioner;
`ifdef INPUT_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  typedef struct {
    logic       rst;
    logic [3:0] sw;
    logic [9:0] exp;
  } vec_t;
  logic i_Clk = 1'b0, i_Reset = 1'b0;
  logic i_Switch_1 = 1'b0, i_Switch_2 = 1'b0, i_Switch_3 = 1'b0, i_Switch_4 = 1'b0;
  logic [3:0] o_Buttons;
  logic o_Up_Pulse, o_Dn_Pulse, o_Rt_Pulse, o_Lt_Pulse, o_Start_Pulse, o_Reset_Pulse;
  logic [9:0] w_obs;
  int checks = 0, errors = 0;
  vec_t tbl[$];
  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(5),
    .CHORD_HOLD(8)
  ) dut (
    .i_Clk(i_Clk),
    .i_Reset(i_Reset),
    .i_Switch_1(i_Switch_1),
    .i_Switch_2(i_Switch_2),
    .i_Switch_3(i_Switch_3),
    .i_Switch_4(i_Switch_4),
    .o_Buttons(o_Buttons),
    .o_Up_Pulse(o_Up_Pulse),
    .o_Dn_Pulse(o_Dn_Pulse),
    .o_Rt_Pulse(o_Rt_Pulse),
    .o_Lt_Pulse(o_Lt_Pulse),
    .o_Start_Pulse(o_Start_Pulse),
    .o_Reset_Pulse(o_Reset_Pulse)
  );
  always #5 i_Clk = ~i_Clk;
  assign w_obs = {o_Buttons, o_Lt_Pulse, o_Rt_Pulse, o_Dn_Pulse, o_Up_Pulse, o_Start_Pulse, o_Reset_Pulse};
  function automatic void push(input logic rst, input logic [3:0] sw, input logic [3:0] btn,
                               input logic [3:0] mv, input logic st, input logic rs);
    vec_t v;
    v.rst = rst;
    v.sw  = sw;
    v.exp = {btn, mv, st, rs};
    tbl.push_back(v);
  endfunction
  task automatic cyc(input logic rst, input logic [3:0] sw);
    i_Reset = rst;
    {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1} = sw;
    @(posedge i_Clk);
    #1;
  endtask
  task automatic chk(input string nm, input int r, input logic [9:0] exp);
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got btn=%b mv=%b st=%b rs=%b, want btn=%b mv=%b st=%b rs=%b",
               nm, r, w_obs[9:6], w_obs[5:2], w_obs[1], w_obs[0], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask
  initial begin
    logic [3:0] sw, eb, mv;
    // reset must dominate even with every switch held
    push(1'b1, 4'b1111, 4'd0, 4'd0, 1'b0, 1'b0);
    push(1'b1, 4'b1111, 4'd0, 4'd0, 1'b0, 1'b0);
    push(1'b1, 4'b0000, 4'd0, 4'd0, 1'b0, 1'b0);
    // clean Switch_1 press: level after 2+4 edges, up pulse one row later; release mirrors the latency
    for (int r = 0; r < 16; r++)
      push(1'b0, r < 9 ? 4'b0001 : 4'b0000, (r >= 5 && r < 14) ? 4'b0001 : 4'b0000,
           r == 6 ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
    // 3-cycle glitch on Switch_2 is the longest one rejected
    for (int r = 0; r < 11; r++)
      push(1'b0, r < 3 ? 4'b0010 : 4'b0000, 4'd0, 4'd0, 1'b0, 1'b0);
    // 4-cycle pulse on Switch_2 is just long enough to be accepted
    for (int r = 0; r < 12; r++)
      push(1'b0, r < 4 ? 4'b0010 : 4'b0000, (r >= 5 && r <= 8) ? 4'b0010 : 4'b0000,
           r == 6 ? 4'b0010 : 4'b0000, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].sw);
      chk("vec", i, tbl[i].exp);
    end
    // auto-repeat on Switch_3: first pulse at row 6, repeats at +10 then every 5 while held
    for (int r = 0; r < 46; r++) begin
      sw = r < 38 ? 4'b0100 : 4'b0000;
      eb = (r >= 5 && r < 43) ? 4'b0100 : 4'b0000;
      mv = (r == 6 || (AR && r >= 16 && r <= 41 && (r - 16) % 5 == 0)) ? 4'b0100 : 4'b0000;
      cyc(1'b0, sw);
      chk("repeat", r, {eb, mv, 2'b00});
    end
    // start chord: one pulse 8 cycles after 0111 appears; dropping to 0011 and back does not re-arm
    for (int r = 0; r < 72; r++) begin
      sw = r < 30 ? 4'b0111 : r < 40 ? 4'b0011 : r < 64 ? 4'b0111 : 4'b0000;
      eb = r < 5 ? 4'b0000 : r < 35 ? 4'b0111 : r < 45 ? 4'b0011 : r < 69 ? 4'b0111 : 4'b0000;
      cyc(1'b0, sw);
      chk("start", r, {eb, 4'b0000, r == 13, 1'b0});
    end
    // escalation: 0111 shown 5 cycles, then 1111 restarts the hold; only the reset strobe fires
    for (int r = 0; r < 34; r++) begin
      sw = r < 5 ? 4'b0111 : r < 26 ? 4'b1111 : 4'b0000;
      eb = r < 5 ? 4'b0000 : r < 10 ? 4'b0111 : r < 31 ? 4'b1111 : 4'b0000;
      cyc(1'b0, sw);
      chk("escalate", r, {eb, 4'b0000, 1'b0, r == 18});
    end
    // reset at hold count 6 cancels the pulse due that edge; the held chord must re-debounce and re-hold
    for (int r = 0; r < 41; r++) begin
      sw = r < 33 ? 4'b1111 : 4'b0000;
      eb = r < 5 ? 4'b0000 : r < 13 ? 4'b1111 : r < 19 ? 4'b0000 : r < 38 ? 4'b1111 : 4'b0000;
      cyc(r == 13, sw);
      chk("midreset", r, {eb, 4'b0000, 1'b0, r == 27});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
